instr_encoder_loader: RTL and testbench

Encoder counterpart to the opcode decoder. Accepts RV32I instruction fields (type, opcode, funct3/funct7, register indices, immediate) over a valid/ready handshake. Packs them into a 32-bit instruction word, checks the immediate for legality, and writes legal words sequentially into instruction memory. Used by the debug/program-load path to fill imem before the core is released from reset.

---
 rtl/instr_encoder_loader.sv | 204 ++++++++++++++++++++
 tb/tb_instr_encoder_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs RV32I instruction fields into 32-bit words,
// checks the immediate, and streams legal words into imem from address 0.
// Handshake: a bundle transfers on a rising edge where i_in_valid and
// o_in_ready are both high; the source holds the bundle stable until then.
module instr_encoder_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [2:0]        i_instr_type,
    input  logic [6:0]        i_opcode,
    input  logic [2:0]        i_funct3,
    input  logic [6:0]        i_funct7,
    input  logic [4:0]        i_rd,
    input  logic [4:0]        i_rs1,
    input  logic [4:0]        i_rs2,
    input  logic [31:0]       i_imm,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic              o_full,
    output logic [ADDR_W:0]   o_word_count,
    output logic              o_err_valid,
    output logic [1:0]        o_err_code,
    output logic              o_err_sticky,
    output logic [1:0]        o_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ENC  = 2'd1,
        S_WR   = 2'd2,
        S_FULL = 2'd3
    } state_t;

    localparam logic [2:0]    T_R = 3'd0, T_I = 3'd1, T_S = 3'd2;
    localparam logic [2:0]    T_B = 3'd3, T_U = 3'd4, T_J = 3'd5;
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

    state_t            r_state, w_state_n;
    logic [2:0]        r_type;
    logic [6:0]        r_opcode, r_funct7;
    logic [2:0]        r_funct3;
    logic [4:0]        r_rd, r_rs1, r_rs2;
    logic [31:0]       r_imm;

    logic              r_in_ready, r_mem_we, r_full, r_err_valid, r_err_sticky;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic [ADDR_W:0]   r_word_count;
    logic [1:0]        r_err_code;

    logic              w_accept;
    logic [31:0]       w_word;
    logic [1:0]        w_chk_code;
    logic signed [31:0] w_imm_s;

    logic              w_in_ready_n, w_mem_we_n, w_full_n, w_err_valid_n, w_err_sticky_n;
    logic [ADDR_W-1:0] w_mem_addr_n;
    logic [31:0]       w_mem_wdata_n;
    logic [ADDR_W:0]   w_word_count_n;
    logic [1:0]        w_err_code_n;

    // clear blocks acceptance even though the ready flag is still high
    assign w_accept = (r_state == S_IDLE) && r_in_ready && i_in_valid && !i_clear;
    assign w_imm_s  = r_imm;

    // Capture the field bundle on the handshake edge
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_type   <= i_instr_type;
            r_opcode <= i_opcode;
            r_funct3 <= i_funct3;
            r_funct7 <= i_funct7;
            r_rd     <= i_rd;
            r_rs1    <= i_rs1;
            r_rs2    <= i_rs2;
            r_imm    <= i_imm;
        end
    end

    // Pack the captured fields into the instruction word for each format
    always_comb begin
        w_word = {25'd0, r_opcode};
        case (r_type)
            T_R: w_word = {r_funct7, r_rs2, r_rs1, r_funct3, r_rd, r_opcode};
            T_I: w_word = {r_imm[11:0], r_rs1, r_funct3, r_rd, r_opcode};
            T_S: w_word = {r_imm[11:5], r_rs2, r_rs1, r_funct3, r_imm[4:0], r_opcode};
            T_B: w_word = {r_imm[12], r_imm[10:5], r_rs2, r_rs1, r_funct3,
                           r_imm[4:1], r_imm[11], r_opcode};
            T_U: w_word = {r_imm[31:12], r_rd, r_opcode};
            T_J: w_word = {r_imm[20], r_imm[10:1], r_imm[11], r_imm[19:12], r_rd, r_opcode};
            default: w_word = {25'd0, r_opcode};
        endcase
    end

    // Legality checks: type/opcode first, then alignment, then range
    always_comb begin
        w_chk_code = 2'd0;
        if (r_type > T_J || r_opcode[1:0] != 2'b11) begin
            w_chk_code = 2'd1;
        end else if ((r_type == T_B || r_type == T_J) && r_imm[0]) begin
            w_chk_code = 2'd2;
        end else begin
            case (r_type)
                T_I, T_S: if (w_imm_s < -32'sd2048 || w_imm_s > 32'sd2047) w_chk_code = 2'd3;
                T_B:      if (w_imm_s < -32'sd4096 || w_imm_s > 32'sd4094) w_chk_code = 2'd3;
                T_J:      if (w_imm_s < -32'sd1048576 || w_imm_s > 32'sd1048574) w_chk_code = 2'd3;
                T_U:      if (r_imm[11:0] != 12'd0) w_chk_code = 2'd3;
                default:  w_chk_code = 2'd0;
            endcase
        end
    end

    // Next state and next registered output values
    always_comb begin
        w_state_n      = r_state;
        w_mem_we_n     = 1'b0;
        w_err_valid_n  = 1'b0;
        w_mem_addr_n   = r_mem_addr;
        w_mem_wdata_n  = r_mem_wdata;
        w_word_count_n = r_word_count;
        w_full_n       = r_full;
        w_err_code_n   = r_err_code;
        w_err_sticky_n = r_err_sticky;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_n = S_ENC;
            end
            S_ENC: begin
                if (w_chk_code != 2'd0) begin
                    w_state_n      = S_IDLE;
                    w_err_valid_n  = 1'b1;
                    w_err_code_n   = w_chk_code;
                    w_err_sticky_n = 1'b1;
                end else begin
                    w_state_n     = S_WR;
                    w_mem_we_n    = 1'b1;
                    w_mem_addr_n  = r_word_count[ADDR_W-1:0];
                    w_mem_wdata_n = w_word;
                end
            end
            S_WR: begin
                w_word_count_n = r_word_count + ONE;
                if (w_word_count_n == DEPTH) begin
                    w_state_n = S_FULL;
                    w_full_n  = 1'b1;
                end else begin
                    w_state_n = S_IDLE;
                end
            end
            S_FULL: w_state_n = S_FULL;
            default: w_state_n = S_IDLE;
        endcase
        w_in_ready_n = (w_state_n == S_IDLE) && !w_full_n;
    end

    // State register; rst and clear both restart from an empty memory
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) r_state <= S_IDLE;
        else                  r_state <= w_state_n;
    end

    // Registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_in_ready   <= 1'b1;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_word_count <= '0;
            r_full       <= 1'b0;
            r_err_valid  <= 1'b0;
            r_err_code   <= 2'd0;
            r_err_sticky <= 1'b0;
        end else begin
            r_in_ready   <= w_in_ready_n;
            r_mem_we     <= w_mem_we_n;
            r_mem_addr   <= w_mem_addr_n;
            r_mem_wdata  <= w_mem_wdata_n;
            r_word_count <= w_word_count_n;
            r_full       <= w_full_n;
            r_err_valid  <= w_err_valid_n;
            r_err_code   <= w_err_code_n;
            r_err_sticky <= w_err_sticky_n;
        end
    end

    assign o_in_ready   = r_in_ready;
    assign o_mem_we     = r_mem_we;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_full       = r_full;
    assign o_word_count = r_word_count;
    assign o_err_valid  = r_err_valid;
    assign o_err_code   = r_err_code;
    assign o_err_sticky = r_err_sticky;
    assign o_state      = r_state;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader with a 4-word memory (ADDR_W=2).
module tb_instr_encoder_loader;
    localparam int ADDR_W = 2;
    localparam int DEPTH  = 4;

    logic              i_clk = 1'b0;
    logic              i_rst, i_clear, i_in_valid;
    logic              o_in_ready;
    logic [2:0]        i_instr_type;
    logic [6:0]        i_opcode, i_funct7;
    logic [2:0]        i_funct3;
    logic [4:0]        i_rd, i_rs1, i_rs2;
    logic [31:0]       i_imm;
    logic              o_mem_we, o_full, o_err_valid, o_err_sticky;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [31:0]       o_mem_wdata;
    logic [ADDR_W:0]   o_word_count;
    logic [1:0]        o_err_code, o_state;

    instr_encoder_loader #(.ADDR_W(ADDR_W)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_clear(i_clear),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
        .i_instr_type(i_instr_type), .i_opcode(i_opcode), .i_funct3(i_funct3),
        .i_funct7(i_funct7), .i_rd(i_rd), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm),
        .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .o_full(o_full), .o_word_count(o_word_count), .o_err_valid(o_err_valid),
        .o_err_code(o_err_code), .o_err_sticky(o_err_sticky), .o_state(o_state)
    );

    // clock / reset
    always #5 i_clk = ~i_clk;

    typedef struct {
        string       name;
        logic        clr;
        logic [2:0]  t;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [1:0]  code;
        logic [31:0] word;
    } vec_t;

    vec_t        vq[$];
    logic [31:0] exp_q[$];
    int          n_pass = 0, n_total = 0;
    int          m_count = 0;
    logic        m_sticky = 1'b0;
    logic [1:0]  m_code = 2'd0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic add(input string nm, input logic clr, input logic [2:0] t, input logic [6:0] op,
                       input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                       input logic [1:0] code, input logic [31:0] word);
        vec_t v;
        v.name = nm; v.clr = clr; v.t = t; v.op = op; v.f3 = f3; v.f7 = f7;
        v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.code = code; v.word = word;
        vq.push_back(v);
    endtask

    task automatic drive_fields(input vec_t v);
        i_instr_type = v.t; i_opcode = v.op; i_funct3 = v.f3; i_funct7 = v.f7;
        i_rd = v.rd; i_rs1 = v.rs1; i_rs2 = v.rs2; i_imm = v.imm;
    endtask

    task automatic pulse_clear();
        i_clear = 1'b1;
        @(posedge i_clk); #1;
        i_clear = 1'b0;
        m_count = 0; m_sticky = 1'b0; m_code = 2'd0;
    endtask

    // driver: waits for ready (bounded), hands over one bundle, watches 4 cycles
    task automatic run_bundle(input vec_t v, output int we_n, output int we_idx,
                              output logic [ADDR_W-1:0] addr, output logic [31:0] data,
                              output int err_n, output logic [1:0] code, output logic rdy0);
        int guard = 0;
        we_n = 0; we_idx = -1; addr = '0; data = '0; err_n = 0; code = 2'd0; rdy0 = 1'b1;
        while (!o_in_ready && guard < 20) begin
            @(posedge i_clk); #1;
            guard++;
        end
        if (!o_in_ready) begin
            chk({v.name, "_ready_wait"}, 0, 1);
            return;
        end
        drive_fields(v);
        i_in_valid = 1'b1;
        @(posedge i_clk); #1;
        i_in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge i_clk);
            if (c == 0) rdy0 = o_in_ready;
            if (o_mem_we) begin
                if (we_n == 0) begin we_idx = c; addr = o_mem_addr; data = o_mem_wdata; end
                we_n++;
            end
            if (o_err_valid) begin err_n++; code = o_err_code; end
        end
        @(posedge i_clk); #1;
    endtask

    // apply one table record and compare against the bench model
    task automatic apply_vec(input vec_t v);
        int we_n, we_idx, err_n;
        logic [ADDR_W-1:0] addr;
        logic [31:0] data;
        logic [1:0] code;
        logic rdy0;
        if (v.clr) pulse_clear();
        if (v.code == 2'd0) exp_q.push_back(v.word);
        run_bundle(v, we_n, we_idx, addr, data, err_n, code, rdy0);
        chk({v.name, "_ready_in_enc"}, rdy0, 0);
        if (v.code == 2'd0) begin
            chk({v.name, "_we_count"}, we_n, 1);
            chk({v.name, "_we_cycle"}, we_idx, 1);
            chk({v.name, "_addr"}, addr, m_count[ADDR_W-1:0]);
            chk({v.name, "_err_none"}, err_n, 0);
            if (exp_q.size() > 0) chk({v.name, "_wdata"}, data, exp_q.pop_front());
            m_count++;
        end else begin
            chk({v.name, "_no_we"}, we_n, 0);
            chk({v.name, "_err_pulse"}, err_n, 1);
            chk({v.name, "_err_code"}, code, v.code);
            m_sticky = 1'b1;
            m_code   = v.code;
        end
        chk({v.name, "_count"}, o_word_count, m_count);
        chk({v.name, "_sticky"}, o_err_sticky, m_sticky);
        chk({v.name, "_code_held"}, o_err_code, m_code);
        chk({v.name, "_full"}, o_full, (m_count == DEPTH));
        chk({v.name, "_ready"}, o_in_ready, (m_count != DEPTH));
    endtask

    task automatic watch_no_we(input string nm, input int cycles);
        int n = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge i_clk);
            if (o_mem_we) n++;
        end
        chk(nm, n, 0);
        @(posedge i_clk); #1;
    endtask

    initial begin
        vec_t v;
        // group A: fills the memory (indices 0..6)
        add("i_addi",     0, 1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5,        2'd0, 32'h00500093);
        add("b_misalign", 0, 3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd7,        2'd2, 32'h0);
        add("s_sw_neg",   0, 2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd3, 5'd2, 32'hFFFFFFFC, 2'd0, 32'hFE21AE23);
        add("b_range",    0, 3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd5000,     2'd3, 32'h0);
        add("u_lui",      0, 4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 2'd0, 32'h123452B7);
        add("bad_type",   0, 7, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0,        2'd1, 32'h0);
        add("r_sub",      0, 0, 7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'hDEADBEEF, 2'd0, 32'h402081B3);
        // group B: clear, then more formats and every rejection kind (indices 7..16)
        add("b_beq",      1, 3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd8,        2'd0, 32'h00000463);
        add("j_jal",      0, 5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd4096,     2'd0, 32'h000010EF);
        add("i_over",     0, 1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048,     2'd3, 32'h0);
        add("bad_opc",    0, 1, 7'h10, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5,        2'd1, 32'h0);
        add("b_over",     0, 3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd4096,     2'd3, 32'h0);
        add("j_over",     0, 5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h00100000, 2'd3, 32'h0);
        add("j_misalign", 0, 5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd3,        2'd2, 32'h0);
        add("u_lowbits",  0, 4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345001, 2'd3, 32'h0);
        add("mis_vs_rng", 0, 3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd5001,     2'd2, 32'h0);
        add("typ_vs_mis", 0, 6, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd1,        2'd1, 32'h0);
        // group C: clear, legal boundary immediates fill the memory again (17..20)
        add("i_min",      1, 1, 7'h13, 3'd0, 7'd0, 5'd2, 5'd2, 5'd0, 32'hFFFFF800, 2'd0, 32'h80010113);
        add("b_max",      0, 3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd4094,     2'd0, 32'h7E000FE3);
        add("j_min",      0, 5, 7'h6F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFF00000, 2'd0, 32'h8000006F);
        add("s_max",      0, 2, 7'h23, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd2047,     2'd0, 32'h7E000FA3);

        i_rst = 1'b1; i_clear = 1'b0; i_in_valid = 1'b0;
        drive_fields(vq[0]);
        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b0;
        chk("rst_state", o_state, 0);
        chk("rst_count", o_word_count, 0);
        chk("rst_outs", {o_mem_we, o_full, o_err_valid, o_err_sticky, o_err_code}, 0);
        chk("rst_ready", o_in_ready, 1);

        for (int i = 0; i < 7; i++) apply_vec(vq[i]);

        // bundle offered while full is ignored
        drive_fields(vq[0]);
        i_in_valid = 1'b1;
        watch_no_we("full_ignore_we", 4);
        i_in_valid = 1'b0;
        chk("full_ignore_state", o_state, 3);
        chk("full_ignore_count", o_word_count, DEPTH);
        chk("full_ignore_ready", o_in_ready, 0);

        for (int i = 7; i < vq.size(); i++) apply_vec(vq[i]);

        // rst during ENC after two writes and an error
        pulse_clear();
        apply_vec(vq[0]);
        apply_vec(vq[2]);
        apply_vec(vq[5]);
        v = vq[4];
        drive_fields(v);
        i_in_valid = 1'b1;
        @(posedge i_clk); #1;
        i_in_valid = 1'b0;
        chk("rst_enc_state", o_state, 1);
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        chk("rst_enc_count", o_word_count, 0);
        chk("rst_enc_outs", {o_mem_we, o_full, o_err_valid, o_err_sticky, o_err_code}, 0);
        chk("rst_enc_addr", o_mem_addr, 0);
        chk("rst_enc_wdata", o_mem_wdata, 0);
        chk("rst_enc_state_idle", o_state, 0);
        watch_no_we("rst_enc_no_we", 3);
        m_count = 0; m_sticky = 1'b0; m_code = 2'd0;

        // clear together with in_valid: bundle refused
        drive_fields(vq[0]);
        i_in_valid = 1'b1; i_clear = 1'b1;
        @(posedge i_clk); #1;
        i_in_valid = 1'b0; i_clear = 1'b0;
        chk("clr_valid_state", o_state, 0);
        chk("clr_valid_ready", o_in_ready, 1);
        watch_no_we("clr_valid_no_we", 3);
        chk("clr_valid_count", o_word_count, 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // overall time bound
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
